// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//   Runtime-configurable UART transmitter. Serialises a byte as
//   start / 5..8 data bits LSB first / optional parity / 1 or 2 stop bits.
//   Every bit lasts cfg_div+1 clocks. Divisor, width, parity, stop count and
//   the data byte are all captured when a frame starts, so configuration may
//   change freely while a frame is on the line.
//
//   Optional feature macro: UART_TX_FIFO_EN
//     defined   : FIFO_DEPTH-entry byte FIFO in front of the serialiser,
//                 frames chain with no idle gap while data is queued.
//     undefined : single-byte handshake, accepted only in IDLE; level = 0.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   cfg_div      clocks per bit minus one
//   cfg_dbits    data bits 00=5 01=6 10=7 11=8
//   cfg_parity   00 none, 01 even, 10 odd, 11 none
//   cfg_stop2    0 one stop bit, 1 two stop bits
//   s_data/s_valid/s_ready  byte input handshake
//   tx           serial line, idle high (registered)
//   busy         frame on the line or bytes queued (registered)
//   level        FIFO occupancy, 0 when the FIFO is not built
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [1:0]                  cfg_dbits,
    input  logic [1:0]                  cfg_parity,
    input  logic                        cfg_stop2,
    input  logic [7:0]                  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_r, state_n;
    logic [DIV_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic             stop_r, stop_n;

    // Per-frame captured configuration and data
    logic [DIV_W-1:0] div_r;
    logic [1:0]       dbits_r;
    logic             par_en_r, par_odd_r, stop2_r;
    logic [7:0]       data_r;

    logic             load_s, last_clk_s, last_data_s;
    logic             src_avail_s, chain_en_s;
    logic [7:0]       src_data_s;
    logic             tx_r, tx_n, s_ready_r, s_ready_n, busy_r, busy_n;

    // Clear the bits above the configured width so parity covers only N bits
    function automatic logic [7:0] mask_data(input logic [7:0] d, input logic [1:0] dbits);
        logic [7:0] m;
        case (dbits)
            2'b00:   m = 8'h1F;
            2'b01:   m = 8'h3F;
            2'b10:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return d & m;
    endfunction

    // Parity bit over already-masked data; odd parity inverts the XOR
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign last_clk_s  = (cnt_r == div_r);
    assign last_data_s = (bit_r == ({1'b0, dbits_r} + 3'd4));

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [LW-1:0] count_r, count_n;
    logic          push_s;

    assign push_s = s_valid & s_ready_r;

    // Occupancy update; a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_n = count_r;
        if (push_s && !load_s) begin
            count_n = count_r + LW'(1);
        end else if (!push_s && load_s) begin
            count_n = count_r - LW'(1);
        end else begin
            count_n = count_r;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (load_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_n;
        end
    end

    assign src_avail_s = (count_r != {LW{1'b0}});
    assign src_data_s  = mem_r[rd_ptr_r];
    assign chain_en_s  = 1'b1;
    // Ready follows the registered full flag only
    assign s_ready_n   = (count_n != LW'(FIFO_DEPTH));
    assign busy_n      = (state_n != ST_IDLE) | (count_n != {LW{1'b0}});
    assign level       = count_r;
`else
    assign src_avail_s = s_valid & s_ready_r;
    assign src_data_s  = s_data;
    assign chain_en_s  = 1'b0;
    assign s_ready_n   = (state_n == ST_IDLE);
    assign busy_n      = (state_n != ST_IDLE);
    assign level       = {($clog2(FIFO_DEPTH) + 1){1'b0}};
`endif

    // State and bit-timing registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {DIV_W{1'b0}};
            bit_r   <= 3'd0;
            stop_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            stop_r  <= stop_n;
        end
    end

    // Next-state logic: each non-idle state lasts div_r+1 clocks
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        bit_n   = bit_r;
        stop_n  = stop_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (src_avail_s) begin
                    load_s  = 1'b1;
                    state_n = ST_START;
                    cnt_n   = {DIV_W{1'b0}};
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (last_clk_s) begin
                    state_n = ST_DATA;
                    cnt_n   = {DIV_W{1'b0}};
                    bit_n   = 3'd0;
                end else begin
                    cnt_n = cnt_r + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (last_clk_s) begin
                    cnt_n = {DIV_W{1'b0}};
                    if (last_data_s) begin
                        state_n = par_en_r ? ST_PARITY : ST_STOP;
                        stop_n  = 1'b0;
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_r + DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (last_clk_s) begin
                    state_n = ST_STOP;
                    cnt_n   = {DIV_W{1'b0}};
                    stop_n  = 1'b0;
                end else begin
                    cnt_n = cnt_r + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (last_clk_s) begin
                    cnt_n = {DIV_W{1'b0}};
                    if (stop_r == stop2_r) begin
                        // Queued data starts the next frame with no idle gap
                        if (chain_en_s && src_avail_s) begin
                            load_s  = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        stop_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + DIV_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = {DIV_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so tx is registered without extra latency
    always_comb begin
        case (state_n)
            ST_IDLE:   tx_n = 1'b1;
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = data_r[bit_n];
            ST_PARITY: tx_n = parity_bit(data_r, par_odd_r);
            ST_STOP:   tx_n = 1'b1;
            default:   tx_n = 1'b1;
        endcase
    end

    // Capture configuration and data at frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r     <= {DIV_W{1'b0}};
            dbits_r   <= 2'b11;
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            stop2_r   <= 1'b0;
            data_r    <= 8'h00;
        end else if (load_s) begin
            div_r     <= cfg_div;
            dbits_r   <= cfg_dbits;
            par_en_r  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd_r <= (cfg_parity == 2'b10);
            stop2_r   <= cfg_stop2;
            data_r    <= mask_data(src_data_s, cfg_dbits);
        end
    end

    // Output registers; reset drives the line idle-high immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r      <= 1'b1;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            tx_r      <= tx_n;
            s_ready_r <= s_ready_n;
            busy_r    <= busy_n;
        end
    end

    assign tx      = tx_r;
    assign s_ready = s_ready_r;
    assign busy    = busy_r;

endmodule
